// File: rtl/nmea_gga_parser_pkg.sv
// nmea_gga_parser_pkg: parser states, ASCII codes, GGA field indices and hex digit decode.
package nmea_gga_parser_pkg;
   typedef enum logic [2:0] {IDLE, HDR, FIELDS, CS_HI, CS_LO, COMMIT} gga_state_t;
   localparam logic [7:0] A_DOLLAR = 8'h24, A_COMMA = 8'h2C, A_STAR = 8'h2A;
   localparam logic [7:0] A_CR = 8'h0D, A_LF = 8'h0A, A_SPACE = 8'h20;
   localparam logic [3:0] F_TIME = 4'd1, F_LAT = 4'd2, F_LATH = 4'd3, F_LON = 4'd4, F_LONH = 4'd5;
   localparam logic [3:0] F_QUAL = 4'd6, F_SATS = 4'd7, F_HDOP = 4'd8, F_ALT = 4'd9, F_GEO = 4'd11;
   // returns {valid, nibble}; accepts upper and lower case hex
   function automatic logic [4:0] hex_nib(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
             ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) ? {1'b1, c[3:0] + 4'd9} : 5'd0;
   endfunction
endpackage

// File: rtl/gps_stale_timer.sv
// gps_stale_timer: ms prescaler plus saturating ms counter; stale is high until cleared and again after the timeout.
module gps_stale_timer #(
   parameter int SYSCLK_FREQ      = 100_000_000,
   parameter int STALE_TIMEOUT_MS = 2000
) (
   input  logic sclk,
   input  logic rstn,
   input  logic clear,
   output logic stale
);
   localparam int TICK = SYSCLK_FREQ / 1000;
   localparam int PW = $clog2(TICK + 1);
   localparam int CW = $clog2(STALE_TIMEOUT_MS + 1);
   logic [PW-1:0] pre;
   logic [CW-1:0] ms;
   logic tick;
   assign tick = pre == PW'(TICK - 1);
   always_ff @(posedge sclk or negedge rstn)
      if (!rstn) begin
         pre   <= '0;
         ms    <= CW'(STALE_TIMEOUT_MS);
         stale <= 1'b1;
      end else if (clear) begin
         pre   <= '0;
         ms    <= '0;
         stale <= 1'b0;
      end else begin
         pre <= tick ? '0 : pre + PW'(1);
         if (tick && !stale) begin
            ms    <= ms + CW'(1);
            stale <= ms + CW'(1) == CW'(STALE_TIMEOUT_MS);
         end
      end
endmodule

// File: rtl/nmea_gga_parser.sv
// nmea_gga_parser: parses $xxGGA sentences from the UART byte stream and commits checksum-verified fields.
module nmea_gga_parser
   import nmea_gga_parser_pkg::*;
#(
   parameter int SYSCLK_FREQ      = 100_000_000,
   parameter int MAX_SENT_LEN     = 82,
   parameter int STALE_TIMEOUT_MS = 2000
) (
   input  logic             sclk,
   input  logic             rstn,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [9:0][7:0]  timestamp,
   output logic [9:0][7:0]  latitude,
   output logic [7:0]       lat_hemi,
   output logic [10:0][7:0] longitude,
   output logic [7:0]       lon_hemi,
   output logic [7:0]       quality,
   output logic [7:0]       numSats,
   output logic [3:0][7:0]  hdop,
   output logic [3:0][7:0]  altMSL,
   output logic [3:0][7:0]  geoid,
   output logic             fix_valid,
   output logic             cs_err,
   output logic             frame_err,
   output logic             fix_stale
);
   gga_state_t state;
   logic [7:0] xsum, rx_cs, len;
   logic [3:0] fidx, cidx;
   logic [9:0][7:0] sh_time, sh_lat;
   logic [10:0][7:0] sh_lon;
   logic [7:0] sh_lath, sh_lonh, sh_qual, sh_sats;
   logic [3:0][7:0] sh_hdop, sh_alt, sh_geo;
   logic [4:0] hex;
   logic [11:0] sats_mul;
   logic [7:0] sats_sat;
   logic is_crlf, is_digit, hdr_ok, len_full, commit_ok;
   assign hex       = hex_nib(rx_data);
   assign is_crlf   = rx_data == A_CR || rx_data == A_LF;
   assign is_digit  = rx_data >= 8'h30 && rx_data <= 8'h39;
   assign hdr_ok    = cidx == 4'd1 ? (rx_data == 8'h50 || rx_data == 8'h4E || rx_data == 8'h4C) :
                      cidx == 4'd4 ? rx_data == 8'h41 : rx_data == 8'h47;
   assign len_full  = len + 8'd1 == 8'(MAX_SENT_LEN);
   assign sats_mul  = 12'(sh_sats) * 12'd10 + 12'(rx_data[3:0]);
   assign sats_sat  = sats_mul > 12'd255 ? 8'hFF : sats_mul[7:0];
   assign commit_ok = state == COMMIT && rx_cs == xsum;
   gps_stale_timer #(.SYSCLK_FREQ(SYSCLK_FREQ), .STALE_TIMEOUT_MS(STALE_TIMEOUT_MS)) u_stale (
      .sclk(sclk), .rstn(rstn), .clear(commit_ok), .stale(fix_stale));
   always_ff @(posedge sclk or negedge rstn)
      if (!rstn) begin
         state <= IDLE;
         {xsum, rx_cs, len, fidx, cidx} <= '0;
         {sh_time, sh_lat, sh_lon, sh_lath, sh_lonh, sh_qual, sh_sats, sh_hdop, sh_alt, sh_geo} <= '0;
         {timestamp, latitude, longitude, lat_hemi, lon_hemi, quality, numSats, hdop, altMSL, geoid} <= '0;
         {fix_valid, cs_err, frame_err} <= '0;
      end else begin
         {fix_valid, cs_err, frame_err} <= '0;
         if (state == COMMIT) begin
            state <= IDLE;
            if (commit_ok) begin
               {timestamp, latitude, lat_hemi, longitude, lon_hemi} <= {sh_time, sh_lat, sh_lath, sh_lon, sh_lonh};
               {quality, numSats, hdop, altMSL, geoid} <= {sh_qual, sh_sats, sh_hdop, sh_alt, sh_geo};
               fix_valid <= 1'b1;
            end else
               cs_err <= 1'b1;
         end
         // '$' restarts from any state, including the commit cycle
         if (rx_valid) begin
            if (rx_data == A_DOLLAR) begin
               state <= HDR;
               {xsum, fidx, cidx} <= '0;
               len <= 8'd1;
               {sh_time, sh_lat} <= {20{A_SPACE}};
               sh_lon <= {11{A_SPACE}};
               {sh_lath, sh_lonh, sh_qual} <= {3{A_SPACE}};
               {sh_hdop, sh_alt, sh_geo} <= {12{A_SPACE}};
               sh_sats <= '0;
            end else case (state)
               HDR:
                  if (!hdr_ok) state <= IDLE;
                  else begin
                     xsum <= xsum ^ rx_data;
                     len  <= len + 8'd1;
                     cidx <= cidx == 4'd4 ? 4'd0 : cidx + 4'd1;
                     if (cidx == 4'd4) state <= FIELDS;
                  end
               FIELDS:
                  if (rx_data == A_STAR) state <= CS_HI;
                  else if (is_crlf || len_full || (fidx == F_SATS && rx_data != A_COMMA && !is_digit)) begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                  end else begin
                     xsum <= xsum ^ rx_data;
                     len  <= len + 8'd1;
                     if (rx_data == A_COMMA) begin
                        fidx <= fidx + 4'(fidx != 4'hF);
                        cidx <= '0;
                     end else begin
                        cidx <= cidx + 4'(cidx != 4'hF);
                        case (fidx)
                           F_TIME: if (cidx < 4'd10) sh_time[4'd9 - cidx] <= rx_data;
                           F_LAT:  if (cidx < 4'd10) sh_lat[4'd9 - cidx] <= rx_data;
                           F_LATH: if (cidx == 4'd0) sh_lath <= rx_data;
                           F_LON:  if (cidx < 4'd11) sh_lon[4'd10 - cidx] <= rx_data;
                           F_LONH: if (cidx == 4'd0) sh_lonh <= rx_data;
                           F_QUAL: if (cidx == 4'd0) sh_qual <= rx_data;
                           F_SATS: sh_sats <= sats_sat;
                           F_HDOP: if (cidx < 4'd4) sh_hdop[2'd3 - cidx[1:0]] <= rx_data;
                           F_ALT:  if (cidx < 4'd4) sh_alt[2'd3 - cidx[1:0]] <= rx_data;
                           F_GEO:  if (cidx < 4'd4) sh_geo[2'd3 - cidx[1:0]] <= rx_data;
                           default: ;
                        endcase
                     end
                  end
               CS_HI, CS_LO: begin
                  if (!hex[4]) begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                  end else if (state == CS_HI) begin
                     rx_cs[7:4] <= hex[3:0];
                     state      <= CS_LO;
                  end else begin
                     rx_cs[3:0] <= hex[3:0];
                     state      <= COMMIT;
                  end
               end
               default: ;
            endcase
         end
      end
endmodule

// File: tb/tb_nmea_gga_parser.sv
// tb_nmea_gga_parser: scoreboard bench; expected pulses/fields are queued as sentences are sent and popped on DUT pulses.
module tb_nmea_gga_parser;
   logic sclk = 1'b0, rstn, rx_valid;
   logic [7:0] rx_data;
   logic [9:0][7:0] timestamp, latitude;
   logic [10:0][7:0] longitude;
   logic [7:0] lat_hemi, lon_hemi, quality, numSats;
   logic [3:0][7:0] hdop, altMSL, geoid;
   logic fix_valid, cs_err, frame_err, fix_stale;
   int checks = 0, errors = 0;
   typedef struct {
      logic [2:0]  kind;
      logic [79:0] ts, lat;
      logic [87:0] lon;
      logic [7:0]  lath, lonh, qual, sats;
      logic [31:0] hdop, alt, geo;
   } exp_t;
   exp_t q[$];
   exp_t exp_a, exp_b, exp_c;
   localparam logic [2:0] K_FIX = 3'b100, K_CS = 3'b010, K_FRAME = 3'b001;
   localparam string A_BODY = "GPGGA,123519.000,4807.03800,N,01131.00000,E,1,08,0.94,545.4,M,46.9,M,,";
   localparam string B_BODY = "GNGGA,235959.123,1234.56789,S,12345.67890,W,2,12,1.5,12.3,M,-3.2,M,,";
   localparam string C_BODY = "GPGGA,,,,,,,300,,,,,,,";
   localparam string R_BODY = "GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";

   nmea_gga_parser #(.SYSCLK_FREQ(10_000)) dut (
      .sclk(sclk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
      .timestamp(timestamp), .latitude(latitude), .lat_hemi(lat_hemi), .longitude(longitude),
      .lon_hemi(lon_hemi), .quality(quality), .numSats(numSats), .hdop(hdop), .altMSL(altMSL),
      .geoid(geoid), .fix_valid(fix_valid), .cs_err(cs_err), .frame_err(frame_err), .fix_stale(fix_stale));

   always #5 sclk = ~sclk;

   task automatic chk(input string tag, input logic [87:0] got, input logic [87:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [87:0] pad(input string s, input int w);
      logic [87:0] r = '0;
      for (int i = 0; i < w; i++) r[(w-1-i)*8 +: 8] = i < s.len() ? s[i] : 8'h20;
      return r;
   endfunction

   function automatic exp_t ev(input logic [2:0] k);
      exp_t e = '{default: '0};
      e.kind = k;
      return e;
   endfunction

   function automatic exp_t fix(input string ts, input string lat, input string lath, input string lon,
                                input string lonh, input string qual, input int sats,
                                input string hd, input string alt, input string geo);
      exp_t e = ev(K_FIX);
      e.ts = 80'(pad(ts, 10)); e.lat = 80'(pad(lat, 10)); e.lon = pad(lon, 11);
      e.lath = 8'(pad(lath, 1)); e.lonh = 8'(pad(lonh, 1)); e.qual = 8'(pad(qual, 1));
      e.sats = 8'(sats);
      e.hdop = 32'(pad(hd, 4)); e.alt = 32'(pad(alt, 4)); e.geo = 32'(pad(geo, 4));
      return e;
   endfunction

   // full sentence with computed checksum; bump alters the last checksum digit
   function automatic string mk(input string body, input bit lower = 1'b0, input int bump = 0);
      logic [7:0] x = '0;
      for (int i = 0; i < body.len(); i++) x ^= body[i];
      x[3:0] = x[3:0] + 4'(bump);
      return {"$", body, "*", lower ? $sformatf("%02x", x) : $sformatf("%02X", x)};
   endfunction

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         rx_data = s[i];
         rx_valid = 1'b1;
         @(posedge sclk); #1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge sclk);
      chk("drain", q.size(), 0);
      @(posedge sclk); #1;
   endtask

   always @(negedge sclk) begin
      exp_t e;
      if (rstn && (fix_valid || cs_err || frame_err)) begin
         if (q.size() == 0) chk("unexpected_pulse", {fix_valid, cs_err, frame_err}, 0);
         else begin
            e = q.pop_front();
            chk("kind", {fix_valid, cs_err, frame_err}, e.kind);
            if (fix_valid) begin
               chk("timestamp", timestamp, e.ts);
               chk("latitude", latitude, e.lat);
               chk("lat_hemi", lat_hemi, e.lath);
               chk("longitude", longitude, e.lon);
               chk("lon_hemi", lon_hemi, e.lonh);
               chk("quality", quality, e.qual);
               chk("numSats", numSats, e.sats);
               chk("hdop", hdop, e.hdop);
               chk("altMSL", altMSL, e.alt);
               chk("geoid", geoid, e.geo);
               chk("stale_drop", fix_stale, 0);
            end
         end
      end
   end

   initial begin
      string s;
      bit seen;
      exp_a = fix("123519.000", "4807.03800", "N", "01131.00000", "E", "1", 8, "0.94", "545.", "46.9");
      exp_b = fix("235959.123", "1234.56789", "S", "12345.67890", "W", "2", 12, "1.5", "12.3", "-3.2");
      exp_c = fix("", "", "", "", "", "", 255, "", "", "");
      rstn = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) @(negedge sclk);
      chk("rst_timestamp", timestamp, 0);
      chk("rst_longitude", longitude, 0);
      chk("rst_numSats", numSats, 0);
      chk("rst_geoid", geoid, 0);
      chk("rst_pulses", {fix_valid, cs_err, frame_err}, 0);
      chk("rst_stale", fix_stale, 1);
      rstn = 1'b1;
      @(posedge sclk); #1;
      // valid GGA with latency check
      q.push_back(exp_a);
      send(mk(A_BODY));
      @(negedge sclk);
      chk("latency_early", fix_valid, 0);
      @(negedge sclk);
      chk("latency", fix_valid, 1);
      drain();
      chk("stale_after_fix", fix_stale, 0);
      // bad checksum leaves outputs alone
      q.push_back(ev(K_CS));
      send(mk(A_BODY, 1'b0, 1));
      drain();
      chk("hold_after_cs", timestamp, exp_a.ts);
      // RMC silently ignored, then GGA commits
      send(mk(R_BODY));
      q.push_back(exp_b);
      send({mk(B_BODY), "\r\n"});
      drain();
      // overlength: abort exactly on char 82
      s = "$GPGGA,";
      for (int i = 0; i < 83; i++) s = {s, "1"};
      send(s.substr(0, 80));
      @(negedge sclk);
      chk("no_frame_81", frame_err, 0);
      q.push_back(ev(K_FRAME));
      send(s.substr(81, 81));
      @(negedge sclk);
      chk("frame_at_82", frame_err, 1);
      send(s.substr(82, 89));
      q.push_back(exp_a);
      send(mk(A_BODY));
      drain();
      // '$' mid-field restarts
      q.push_back(exp_b);
      send("$GPGGA,1235");
      send(mk(B_BODY));
      drain();
      // abort cases and silent header CR
      q.push_back(ev(K_FRAME));
      send("$GPGGA,1,2,N,3,E,1,0x");
      drain();
      q.push_back(ev(K_FRAME));
      send("$GPGGA,12\r");
      drain();
      q.push_back(ev(K_FRAME));
      send("$GPGGA,1*G");
      drain();
      send("$GP\r");
      drain();
      // empty fields, saturating sats, lower-case checksum, '$' in commit cycle
      q.push_back(exp_c);
      q.push_back(exp_a);
      send({mk(C_BODY, 1'b1), mk(A_BODY)});
      drain();
      // async reset mid-sentence
      send("$GPGGA,1235");
      #3 rstn = 1'b0;
      #1;
      chk("async_rst_ts", timestamp, 0);
      chk("async_rst_hemi", lat_hemi, 0);
      chk("async_rst_stale", fix_stale, 1);
      @(negedge sclk) rstn = 1'b1;
      @(posedge sclk); #1;
      send(",000,4807.038,N*00");
      repeat (20010) @(negedge sclk);
      chk("idle_stale", fix_stale, 1);
      chk("idle_ts", timestamp, 0);
      chk("idle_sats", numSats, 0);
      @(posedge sclk); #1;
      q.push_back(exp_a);
      send(mk(A_BODY));
      drain();
      repeat (19990) @(negedge sclk);
      chk("stale_before_timeout", fix_stale, 0);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge sclk);
         seen = fix_stale;
      end
      chk("stale_reassert", fix_stale, 1);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
